// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative multiply/divide unit owning the HI/LO registers
// Radix-R shift-add multiply, restoring divide, sign fix-up in a final FIX cycle.
module mdu_iter #(
  parameter int WIDTH       = 32,
  parameter int MUL_RADIX_B = 1
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] src_a_i,
  input  logic [WIDTH-1:0] src_b_i,
  input  logic             write_hi_i,
  input  logic             write_lo_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_by_zero_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);
  localparam int R  = MUL_RADIX_B;
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] MUL_LAST = CW'(WIDTH / MUL_RADIX_B - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   opnd_q;
  logic [2*WIDTH-1:0] acc_q;
  logic               sign_p_q, sign_r_q, is_div_q, dz_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q, dbz_q;

  // Operand magnitudes; for signed ops 0 - min_neg wraps to the correct unsigned magnitude.
  logic             sa, sb;
  logic [WIDTH:0]   mag_a, mag_b;
  always_comb begin
    sa    = ~op_i[0] & src_a_i[WIDTH-1];
    sb    = ~op_i[0] & src_b_i[WIDTH-1];
    mag_a = sa ? ({1'b0, {WIDTH{1'b0}}} - {1'b0, src_a_i}) : {1'b0, src_a_i};
    mag_b = sb ? ({1'b0, {WIDTH{1'b0}}} - {1'b0, src_b_i}) : {1'b0, src_b_i};
  end

  // One multiply step: add opnd * low R multiplier bits into the upper half, shift right R.
  logic [WIDTH+R-1:0] mul_pp, mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  always_comb begin
    mul_pp   = {{R{1'b0}}, opnd_q} * {{WIDTH{1'b0}}, acc_q[R-1:0]};
    mul_sum  = {{R{1'b0}}, acc_q[2*WIDTH-1:WIDTH]} + mul_pp;
    mul_next = {mul_sum, acc_q[WIDTH-1:R]};
  end

  // One restoring divide step: acc = {remainder, dividend/quotient}.
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] div_next;
  always_comb begin
    div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, opnd_q};
    div_next  = div_trial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                 : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
  end

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, fix_hi, fix_lo;
  always_comb begin
    prod_fix = sign_p_q ? (2*WIDTH)'(-acc_q) : acc_q;
    quo_fix  = sign_p_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = sign_r_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    if (is_div_q) begin
      fix_hi = rem_fix;
      fix_lo = dz_q ? {WIDTH{1'b1}} : quo_fix;
    end else begin
      fix_hi = prod_fix[2*WIDTH-1:WIDTH];
      fix_lo = prod_fix[WIDTH-1:0];
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = op_i[1] ? S_DIV : S_MUL;
      S_MUL:   if (cnt_q == MUL_LAST) state_d = S_FIX;
      S_DIV:   if (cnt_q == DIV_LAST) state_d = S_FIX;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state_q != S_IDLE);
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      cnt_q    <= '0;
      opnd_q   <= '0;
      acc_q    <= '0;
      sign_p_q <= 1'b0;
      sign_r_q <= 1'b0;
      is_div_q <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (write_hi_i) hi_q <= wdata_i;
          if (write_lo_i) lo_q <= wdata_i;
          if (start_i) begin
            cnt_q    <= '0;
            sign_p_q <= sa ^ sb;
            sign_r_q <= sa;
            is_div_q <= op_i[1];
            dz_q     <= op_i[1] & (src_b_i == '0);
            opnd_q   <= op_i[1] ? mag_b[WIDTH-1:0] : mag_a[WIDTH-1:0];
            acc_q    <= {{WIDTH{1'b0}}, op_i[1] ? mag_a[WIDTH-1:0] : mag_b[WIDTH-1:0]};
          end
        end
        S_MUL: begin
          acc_q <= mul_next;
          cnt_q <= cnt_q + 1'b1;
        end
        S_DIV: begin
          acc_q <= div_next;
          cnt_q <= cnt_q + 1'b1;
        end
        default: begin
          hi_q   <= fix_hi;
          lo_q   <= fix_lo;
          done_q <= 1'b1;
          dbz_q  <= dz_q;
        end
      endcase
    end
  end

  assign done_o        = done_q;
  assign div_by_zero_o = dbz_q;
  assign hi_o          = hi_q;
  assign lo_o          = lo_q;
endmodule

// File: tb/tb_mdu_iter.sv
// tb/tb_mdu_iter.sv - self-checking bench for mdu_iter
module tb_mdu_iter;
  localparam int W = 32;

  logic         clock, reset, start, write_hi, write_lo;
  logic [1:0]   op;
  logic [W-1:0] src_a, src_b, wdata;
  logic         busy, done, dbz;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int errors = 0;

  mdu_iter #(.WIDTH(W), .MUL_RADIX_B(2)) dut (
    .clock_i(clock), .reset_i(reset), .start_i(start), .op_i(op),
    .src_a_i(src_a), .src_b_i(src_b), .write_hi_i(write_hi), .write_lo_i(write_lo),
    .wdata_i(wdata), .busy_o(busy), .done_o(done), .div_by_zero_o(dbz),
    .hi_o(hi), .lo_o(lo)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        dz;
    int          bcyc;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: {dz, hi, lo} from plain 64-bit / integer arithmetic.
  function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    int sa, sb, q, r;
    case (o)
      2'd0: begin
        p = longint'($signed(a)) * longint'($signed(b));
        return {1'b0, p};
      end
      2'd1: begin
        p = {32'd0, a} * {32'd0, b};
        return {1'b0, p};
      end
      2'd2: begin
        if (b == 0) return {1'b1, a, 32'hFFFFFFFF};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {1'b0, 32'd0, a};
        sa = a; sb = b; q = sa / sb; r = sa % sb;
        return {1'b0, r, q};
      end
      default: begin
        if (b == 0) return {1'b1, a, 32'hFFFFFFFF};
        return {1'b0, a % b, a / b};
      end
    endcase
  endfunction

  // Issue an op at the current sample point (1 time unit after a rising edge).
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit poke, output int bcyc, output bit saw_done);
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(posedge clock); #1;
    start = poke;
    op = 2'($urandom); src_a = $urandom; src_b = $urandom;
    bcyc = 0; saw_done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (!busy) begin
        saw_done = done;
        break;
      end
      bcyc++;
      if (i >= 4) start = 1'b0;
      @(posedge clock); #1;
    end
    start = 1'b0;
  endtask

  vec_t vecs[9];
  int   bc;
  bit   sd, seen;
  logic [64:0] exp;
  logic [31:0] ra, rb;
  logic [1:0]  ro;

  initial begin
    vecs[0] = '{2'd0, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 17};
    vecs[1] = '{2'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33};
    vecs[2] = '{2'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33};
    vecs[3] = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0, 33};
    vecs[4] = '{2'd3, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1'b1, 33};
    vecs[5] = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd1, 1'b0, 17};
    vecs[6] = '{2'd2, 32'hFFFFFFF7, 32'd0, 32'hFFFFFFF7, 32'hFFFFFFFF, 1'b1, 33};
    vecs[7] = '{2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'd0, 1'b0, 17};
    vecs[8] = '{2'd0, 32'h80000000, 32'd1, 32'hFFFFFFFF, 32'h80000000, 1'b0, 17};

    reset = 1'b1; start = 1'b0; op = 2'd0; src_a = '0; src_b = '0;
    write_hi = 1'b0; write_lo = 1'b0; wdata = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_busy", busy, 0); chk("reset_done", done, 0); chk("reset_dbz", dbz, 0);
    chk("reset_hi", hi, 0); chk("reset_lo", lo, 0);
    reset = 1'b0;
    @(posedge clock); #1;

    for (int i = 0; i < 9; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, bc, sd);
      chk($sformatf("vec%0d_bcyc", i), bc, vecs[i].bcyc);
      chk($sformatf("vec%0d_done", i), sd, 1);
      chk($sformatf("vec%0d_hi", i), hi, vecs[i].hi);
      chk($sformatf("vec%0d_lo", i), lo, vecs[i].lo);
      chk($sformatf("vec%0d_dbz", i), dbz, vecs[i].dz);
      @(posedge clock); #1;
      chk($sformatf("vec%0d_done_pulse", i), done, 0);
    end

    // div_by_zero holds until the next done
    do_op(2'd3, 32'd9, 32'd0, 1'b0, bc, sd);
    repeat (3) @(posedge clock);
    #1;
    chk("dbz_hold", dbz, 1);

    // MTHI in idle, then both strobes together
    write_hi = 1'b1; wdata = 32'd1234;
    @(posedge clock); #1;
    write_hi = 1'b0;
    chk("mthi_hi", hi, 32'd1234);
    write_hi = 1'b1; write_lo = 1'b1; wdata = 32'hA5A5_0001;
    @(posedge clock); #1;
    write_hi = 1'b0; write_lo = 1'b0;
    chk("mthilo_hi", hi, 32'hA5A5_0001); chk("mthilo_lo", lo, 32'hA5A5_0001);

    // MTHI coincident with start is applied, MTLO while busy ignored, result wins at FIX
    write_hi = 1'b1; wdata = 32'hCAFE_0000; start = 1'b1; op = 2'd1; src_a = 32'd6; src_b = 32'd7;
    @(posedge clock); #1;
    write_hi = 1'b0; start = 1'b0;
    chk("mthi_with_start", hi, 32'hCAFE_0000);
    write_lo = 1'b1; wdata = 32'h1111_2222;
    @(posedge clock); #1;
    write_lo = 1'b0;
    chk("mtlo_busy_ignored", lo, 32'hA5A5_0001);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clock); #1;
      seen = done;
    end
    chk("wr_op_done", seen, 1); chk("wr_op_hi", hi, 0); chk("wr_op_lo", lo, 42);

    // start while busy with other operands is ignored
    do_op(2'd2, 32'hFFFFFF9C, 32'd7, 1'b1, bc, sd);
    exp = model(2'd2, 32'hFFFFFF9C, 32'd7);
    chk("poke_bcyc", bc, 33); chk("poke_hi", hi, exp[63:32]); chk("poke_lo", lo, exp[31:0]);

    // back-to-back: start on the done cycle
    do_op(2'd1, 32'd3, 32'd4, 1'b0, bc, sd);
    chk("b2b_first_done", sd, 1);
    start = 1'b1; op = 2'd0; src_a = 32'hFFFFFFFF; src_b = 32'hFFFFFFFF;
    @(posedge clock); #1;
    start = 1'b0;
    chk("b2b_busy", busy, 1);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clock); #1;
      seen = done;
    end
    chk("b2b_done", seen, 1); chk("b2b_hi", hi, 0); chk("b2b_lo", lo, 1);

    // reset in mid-operation discards the result
    start = 1'b1; op = 2'd1; src_a = 32'hFFFFFFFF; src_b = 32'hFFFFFFFF;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    chk("rst_mid_busy", busy, 0); chk("rst_mid_hi", hi, 0); chk("rst_mid_lo", lo, 0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) seen = 1'b1;
      @(posedge clock); #1;
    end
    chk("rst_mid_no_done", seen, 0);

    // randomized ops against the reference model
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom);
      ra = $urandom; rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: ra = 32'h80000000;
        2: rb = 32'($urandom_range(1, 15));
        3: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
        default: ;
      endcase
      do_op(ro, ra, rb, ($urandom_range(0, 3) == 0), bc, sd);
      exp = model(ro, ra, rb);
      chk($sformatf("rnd%0d_done", i), sd, 1);
      chk($sformatf("rnd%0d_bcyc", i), bc, ro[1] ? 33 : 17);
      chk($sformatf("rnd%0d_res op%0d a=%h b=%h", i, ro, ra, rb), {dbz, hi, lo}, exp);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
